// File: rtl/rscl_decode_pkg.sv
// Shared types and encodings for the rscl decode stage.
package rscl_decode_pkg;

  typedef enum logic [3:0] {
    OP_ALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
    OP_LUI, OP_AUIPC, OP_SYSTEM, OP_FENCE, OP_MULDIV
  } op_t;

  typedef enum logic [1:0] {
    EXC_NONE, EXC_FETCH, EXC_ILLEGAL
  } exc_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Bubble encoding fetch presents when it has nothing; decodes as addi x0,x0,0.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/rscl_imm_gen.sv
// Immediate extraction by RV32I instruction format; bit 31 is the sign.
module rscl_imm_gen
  import rscl_decode_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [31:0] imm_o
);

  always_comb begin
    imm_o = '0;
    case (instr_i[6:0])
      OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM, OPC_FENCE:
        imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      OPC_STORE:
        imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      OPC_BRANCH:
        imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm_o = {instr_i[31:12], 12'b0};
      OPC_JAL:
        imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/rscl_decode.sv
// RV32I decode stage: registered ID/EX record, load-use bubble, jump flush.
// Define RSCL_DECODE_M_EN to decode the M-extension (funct7=0000001) as OP_MULDIV.
module rscl_decode
  import rscl_decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_instr,
  input  logic        fetch_err,
  output logic        fetch_stall,
  input  logic        jump,
  input  logic        exec_stall,
  output logic [4:0]  rf_rs1,
  output logic [4:0]  rf_rs2,
  output logic        dec_valid,
  output op_t         dec_op,
  output logic [3:0]  dec_funct,
  output logic [4:0]  dec_rd,
  output logic [4:0]  dec_rs1,
  output logic [4:0]  dec_rs2,
  output logic [31:0] dec_imm,
  output exc_t        dec_exc
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_raw;

  logic        valid_q;
  op_t         op_q, op_d;
  logic [3:0]  funct_q, funct_d;
  logic [4:0]  rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [31:0] imm_q, imm_d;
  exc_t        exc_q, exc_d;

  logic legal, uses_rs1, uses_rs2, has_rd, hazard;

  assign opc    = fetch_instr[6:0];
  assign f3     = fetch_instr[14:12];
  assign f7     = fetch_instr[31:25];
  assign rf_rs1 = fetch_instr[19:15];
  assign rf_rs2 = fetch_instr[24:20];

  rscl_imm_gen u_imm_gen (
    .instr_i (fetch_instr),
    .imm_o   (imm_raw)
  );

  always_comb begin
    op_d     = OP_ALU;
    funct_d  = {1'b0, f3};
    legal    = 1'b1;
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    has_rd   = 1'b1;
    case (opc)
      OPC_LUI:    begin op_d = OP_LUI;   uses_rs1 = 1'b0; funct_d = 4'd0; end
      OPC_AUIPC:  begin op_d = OP_AUIPC; uses_rs1 = 1'b0; funct_d = 4'd0; end
      OPC_JAL:    begin op_d = OP_JAL;   uses_rs1 = 1'b0; funct_d = 4'd0; end
      OPC_JALR:   begin op_d = OP_JALR;  legal = (f3 == 3'b000); end
      OPC_BRANCH: begin
        op_d = OP_BRANCH; uses_rs2 = 1'b1; has_rd = 1'b0;
        legal = (f3[2:1] != 2'b01);
      end
      OPC_LOAD: begin
        op_d  = OP_LOAD;
        legal = (f3 != 3'b011) && (f3[2:1] != 2'b11);
      end
      OPC_STORE: begin
        op_d = OP_STORE; uses_rs2 = 1'b1; has_rd = 1'b0;
        legal = (f3[2] == 1'b0) && (f3 != 3'b011);
      end
      OPC_OPIMM: begin
        // Only shift-immediates carry a funct7; other I-types keep bit 30 as immediate.
        funct_d = {(f3 == 3'b101) & f7[5], f3};
        if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
        else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
      end
      OPC_OP: begin
        uses_rs2 = 1'b1;
        if (f7 == 7'b0000000) begin
          funct_d = {1'b0, f3};
        end else if (f7 == 7'b0100000) begin
          funct_d = {1'b1, f3};
          legal   = (f3 == 3'b000) || (f3 == 3'b101);
        end else if (f7 == 7'b0000001) begin
`ifdef RSCL_DECODE_M_EN
          op_d    = OP_MULDIV;
          funct_d = {1'b0, f3};
`else
          legal   = 1'b0;
`endif
        end else begin
          legal = 1'b0;
        end
      end
      OPC_FENCE:  op_d = OP_FENCE;
      OPC_SYSTEM: begin op_d = OP_SYSTEM; legal = (f3 != 3'b100); end
      default:    legal = 1'b0;
    endcase

    exc_d = fetch_err ? EXC_FETCH : (legal ? EXC_NONE : EXC_ILLEGAL);
    imm_d = imm_raw;
    if (exc_d != EXC_NONE) begin
      op_d     = OP_ALU;
      funct_d  = 4'd0;
      imm_d    = '0;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      has_rd   = 1'b0;
    end
    rd_d  = has_rd   ? fetch_instr[11:7]  : 5'd0;
    rs1_d = uses_rs1 ? fetch_instr[19:15] : 5'd0;
    rs2_d = uses_rs2 ? fetch_instr[24:20] : 5'd0;

    hazard = valid_q && (op_q == OP_LOAD) && (exc_q == EXC_NONE) && (rd_q != 5'd0) &&
             ((uses_rs1 && (rf_rs1 == rd_q)) || (uses_rs2 && (rf_rs2 == rd_q)));
  end

  assign fetch_stall = ~rst & (exec_stall | hazard);

  // ID/EX record: jump > exec_stall > hazard bubble > load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      op_q    <= OP_ALU;
      funct_q <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      exc_q   <= EXC_NONE;
    end else if (jump) begin
      valid_q <= 1'b0;
    end else if (exec_stall) begin
      valid_q <= valid_q;
    end else if (hazard) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b1;
      op_q    <= op_d;
      funct_q <= funct_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
      exc_q   <= exc_d;
    end
  end

  assign dec_valid = valid_q;
  assign dec_op    = op_q;
  assign dec_funct = funct_q;
  assign dec_rd    = rd_q;
  assign dec_rs1   = rs1_q;
  assign dec_rs2   = rs2_q;
  assign dec_imm   = imm_q;
  assign dec_exc   = exc_q;

endmodule

// File: tb/tb_rscl_decode.sv
// Directed bench for rscl_decode with hand-computed expected records.
module tb_rscl_decode;
  import rscl_decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_instr;
  logic        fetch_err;
  logic        fetch_stall;
  logic        jump;
  logic        exec_stall;
  logic [4:0]  rf_rs1, rf_rs2;
  logic        dec_valid;
  op_t         dec_op;
  logic [3:0]  dec_funct;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic [31:0] dec_imm;
  exc_t        dec_exc;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rscl_decode dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_instr (fetch_instr),
    .fetch_err   (fetch_err),
    .fetch_stall (fetch_stall),
    .jump        (jump),
    .exec_stall  (exec_stall),
    .rf_rs1      (rf_rs1),
    .rf_rs2      (rf_rs2),
    .dec_valid   (dec_valid),
    .dec_op      (dec_op),
    .dec_funct   (dec_funct),
    .dec_rd      (dec_rd),
    .dec_rs1     (dec_rs1),
    .dec_rs2     (dec_rs2),
    .dec_imm     (dec_imm),
    .dec_exc     (dec_exc)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; fetch_instr = 32'h0050_0093; fetch_err = 1'b0; jump = 1'b0; exec_stall = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 32'(dec_valid), 32'd0);
    chk("rst_stall", 32'(fetch_stall), 32'd0);
    chk("rst_op", 32'(dec_op), 32'(OP_ALU));
    chk("rst_exc", 32'(dec_exc), 32'(EXC_NONE));
    chk("rst_rd", 32'(dec_rd), 32'd0);
    chk("rst_imm", dec_imm, 32'd0);

    // addi x1,x0,5 loaded on first edge after release
    rst = 1'b0;
    tick();
    chk("addi_valid", 32'(dec_valid), 32'd1);
    chk("addi_op", 32'(dec_op), 32'(OP_ALU));
    chk("addi_rd", 32'(dec_rd), 32'd1);
    chk("addi_rs1", 32'(dec_rs1), 32'd0);
    chk("addi_imm", dec_imm, 32'd5);
    chk("addi_exc", 32'(dec_exc), 32'(EXC_NONE));

    // lw x5,0(x2) then dependent add x6,x5,x1
    fetch_instr = 32'h0001_2283;
    tick();
    chk("lw_op", 32'(dec_op), 32'(OP_LOAD));
    chk("lw_rd", 32'(dec_rd), 32'd5);
    chk("lw_rs1", 32'(dec_rs1), 32'd2);
    fetch_instr = 32'h0012_8333;
    #1;
    chk("hz_stall", 32'(fetch_stall), 32'd1);
    chk("hz_rfrs1", 32'(rf_rs1), 32'd5);
    chk("hz_rfrs2", 32'(rf_rs2), 32'd1);
    tick();
    chk("hz_bubble", 32'(dec_valid), 32'd0);
    chk("hz_stall_clr", 32'(fetch_stall), 32'd0);
    tick();
    chk("add_valid", 32'(dec_valid), 32'd1);
    chk("add_op", 32'(dec_op), 32'(OP_ALU));
    chk("add_rd", 32'(dec_rd), 32'd6);
    chk("add_rs1", 32'(dec_rs1), 32'd5);
    chk("add_rs2", 32'(dec_rs2), 32'd1);
    chk("add_imm", dec_imm, 32'd0);

    // addi x7,x0,-1 then exec_stall for three cycles
    fetch_instr = 32'hFFF0_0393;
    tick();
    chk("neg_imm", dec_imm, 32'hFFFF_FFFF);
    fetch_instr = 32'h00C0_0413;
    exec_stall  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("es_stall", 32'(fetch_stall), 32'd1);
      tick();
      chk("es_rd", 32'(dec_rd), 32'd7);
      chk("es_imm", dec_imm, 32'hFFFF_FFFF);
      chk("es_valid", 32'(dec_valid), 32'd1);
    end
    exec_stall = 1'b0;
    tick();
    chk("es_load_rd", 32'(dec_rd), 32'd8);
    chk("es_load_imm", dec_imm, 32'd12);

    // jump with exec_stall kills the record; lui x9 must never appear
    jump = 1'b1; exec_stall = 1'b1; fetch_instr = 32'h1234_54B7;
    tick();
    chk("jmp_valid", 32'(dec_valid), 32'd0);
    jump = 1'b0; exec_stall = 1'b0; fetch_instr = 32'h0000_1597;
    tick();
    chk("auipc_op", 32'(dec_op), 32'(OP_AUIPC));
    chk("auipc_rd", 32'(dec_rd), 32'd11);
    chk("auipc_imm", dec_imm, 32'h0000_1000);

    // sw x7,4(x2)
    fetch_instr = 32'h0071_2223;
    tick();
    chk("sw_op", 32'(dec_op), 32'(OP_STORE));
    chk("sw_imm", dec_imm, 32'd4);
    chk("sw_rs2", 32'(dec_rs2), 32'd7);
    chk("sw_funct", 32'(dec_funct), 32'd2);

    // beq x0,x0,-4
    fetch_instr = 32'hFE00_0EE3;
    tick();
    chk("beq_op", 32'(dec_op), 32'(OP_BRANCH));
    chk("beq_imm", dec_imm, 32'hFFFF_FFFC);

    // jal x1,+8
    fetch_instr = 32'h0080_00EF;
    tick();
    chk("jal_op", 32'(dec_op), 32'(OP_JAL));
    chk("jal_imm", dec_imm, 32'd8);
    chk("jal_rd", 32'(dec_rd), 32'd1);

    // bus error wins over illegal encoding
    fetch_instr = 32'hFFFF_FFFF; fetch_err = 1'b1;
    tick();
    chk("ferr_exc", 32'(dec_exc), 32'(EXC_FETCH));
    chk("ferr_op", 32'(dec_op), 32'(OP_ALU));
    chk("ferr_rd", 32'(dec_rd), 32'd0);
    fetch_err = 1'b0;
    tick();
    chk("ill_exc", 32'(dec_exc), 32'(EXC_ILLEGAL));
    chk("ill_rd", 32'(dec_rd), 32'd0);
    chk("ill_valid", 32'(dec_valid), 32'd1);

    // mul x1,x1,x2
    fetch_instr = 32'h0220_80B3;
    tick();
`ifdef RSCL_DECODE_M_EN
    chk("mul_op", 32'(dec_op), 32'(OP_MULDIV));
    chk("mul_exc", 32'(dec_exc), 32'(EXC_NONE));
    chk("mul_rd", 32'(dec_rd), 32'd1);
    chk("mul_rs2", 32'(dec_rs2), 32'd2);
`else
    chk("mul_exc", 32'(dec_exc), 32'(EXC_ILLEGAL));
    chk("mul_rd", 32'(dec_rd), 32'd0);
`endif

    // NOP bubble decodes as ordinary ALU op
    fetch_instr = NOP_INSTR;
    tick();
    chk("nop_op", 32'(dec_op), 32'(OP_ALU));
    chk("nop_exc", 32'(dec_exc), 32'(EXC_NONE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
